// File: rtl/x86_decode_pkg.sv
// Shared x86-64 decode constants, per-opcode attribute tables and ModRM sizing.
// Pure combinational helpers; no state.
package x86_decode_pkg;

    localparam logic [7:0] PFX_LOCK     = 8'hF0;
    localparam logic [7:0] PFX_REPNE    = 8'hF2;
    localparam logic [7:0] PFX_REP      = 8'hF3;
    localparam logic [7:0] PFX_CS       = 8'h2E;
    localparam logic [7:0] PFX_SS       = 8'h36;
    localparam logic [7:0] PFX_DS       = 8'h3E;
    localparam logic [7:0] PFX_ES       = 8'h26;
    localparam logic [7:0] PFX_FS       = 8'h64;
    localparam logic [7:0] PFX_GS       = 8'h65;
    localparam logic [7:0] PFX_OPSIZE   = 8'h66;
    localparam logic [7:0] PFX_ADDRSIZE = 8'h67;
    localparam logic [7:0] REX_LO       = 8'h40;
    localparam logic [7:0] REX_HI       = 8'h4F;
    localparam logic [7:0] OPC_ESC      = 8'h0F;
    localparam logic [7:0] OPC_MAP38    = 8'h38;
    localparam logic [7:0] OPC_MAP3A    = 8'h3A;

    typedef enum logic [2:0] {
        IK_NONE,
        IK_IMM8,
        IK_IMM16,
        IK_IMMZ,
        IK_IMMV64,
        IK_IMM24,
        IK_MOFFS
    } imm_kind_e;

    typedef struct packed {
        logic      has_modrm;
        imm_kind_e imm;
        logic      illegal_64;
    } attr_t;

    function automatic logic is_legacy_prefix(input logic [7:0] b);
        return b inside {PFX_LOCK, PFX_REPNE, PFX_REP, PFX_CS, PFX_SS, PFX_DS,
                         PFX_ES, PFX_FS, PFX_GS, PFX_OPSIZE, PFX_ADDRSIZE};
    endfunction

    function automatic attr_t one_byte_attr(input logic [7:0] op);
        attr_t a;
        a.has_modrm  = 1'b0;
        a.imm        = IK_NONE;
        a.illegal_64 = 1'b0;
        // ALU rows 0-3: columns x0-x3/x8-xB take ModRM, x4/xC imm8, x5/xD immz
        if (op[7:6] == 2'b00 && !op[2]) a.has_modrm = 1'b1;
        if (op inside {8'h63, 8'h69, 8'h6B, [8'h80:8'h8F], 8'hC0, 8'hC1, 8'hC6, 8'hC7,
                       [8'hD0:8'hD3], [8'hD8:8'hDF], 8'hF6, 8'hF7, 8'hFE, 8'hFF})
            a.has_modrm = 1'b1;
        if (op[7:6] == 2'b00 && op[2:0] == 3'd4) a.imm = IK_IMM8;
        if (op[7:6] == 2'b00 && op[2:0] == 3'd5) a.imm = IK_IMMZ;
        if (op inside {8'h6A, 8'h6B, [8'h70:8'h7F], 8'h80, 8'h83, 8'hA8, [8'hB0:8'hB7],
                       8'hC0, 8'hC1, 8'hC6, 8'hCD, [8'hE0:8'hE7], 8'hEB, 8'hF6})
            a.imm = IK_IMM8;
        if (op inside {8'h68, 8'h69, 8'h81, 8'hA9, 8'hC7, 8'hE8, 8'hE9, 8'hF7})
            a.imm = IK_IMMZ;
        if (op inside {[8'hB8:8'hBF]}) a.imm = IK_IMMV64;
        if (op inside {8'hC2, 8'hCA})  a.imm = IK_IMM16;
        if (op == 8'hC8)               a.imm = IK_IMM24;
        if (op inside {[8'hA0:8'hA3]}) a.imm = IK_MOFFS;
        if (op inside {8'h06, 8'h07, 8'h0E, 8'h16, 8'h17, 8'h1E, 8'h1F, 8'h27, 8'h2F,
                       8'h37, 8'h3F, 8'h60, 8'h61, 8'h62, 8'h82, 8'h9A, 8'hC4, 8'hC5,
                       8'hD4, 8'hD5, 8'hD6, 8'hEA}) begin
            a.has_modrm  = 1'b0;
            a.imm        = IK_NONE;
            a.illegal_64 = 1'b1;
        end
        return a;
    endfunction

    function automatic attr_t two_byte_attr(input logic [7:0] op);
        attr_t a;
        a.has_modrm  = !(op inside {[8'h05:8'h09], 8'h0B, [8'h30:8'h37], 8'h77, [8'h80:8'h8F],
                                    [8'hA0:8'hA2], [8'hA8:8'hAA], [8'hC8:8'hCF]});
        a.imm        = IK_NONE;
        a.illegal_64 = 1'b0;
        if (op inside {[8'h70:8'h73], 8'hA4, 8'hAC, 8'hBA, 8'hC2, [8'hC4:8'hC6]})
            a.imm = IK_IMM8;
        if (op inside {[8'h80:8'h8F]}) a.imm = IK_IMMZ;
        return a;
    endfunction

    // Bytes following ModRM: optional SIB plus displacement (0..5).
    function automatic logic [2:0] modrm_ext_len(input logic [7:0] modrm, input logic [2:0] sib_base);
        logic       has_sib;
        logic [2:0] disp;
        has_sib = (modrm[7:6] != 2'b11) && (modrm[2:0] == 3'd4);
        disp    = 3'd0;
        case (modrm[7:6])
            2'b00:   if (modrm[2:0] == 3'd5 || (has_sib && sib_base == 3'd5)) disp = 3'd4;
            2'b01:   disp = 3'd1;
            2'b10:   disp = 3'd4;
            default: disp = 3'd0;
        endcase
        return disp + {2'b00, has_sib};
    endfunction

endpackage

// File: rtl/x86_modrm_len.sv
// ModRM + SIB base field -> count of SIB/displacement bytes after ModRM.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module x86_modrm_len
    import x86_decode_pkg::*;
(
    input  logic [7:0] modrm,
    input  logic [2:0] sib_base,
    output logic [2:0] ext_len,
    output logic [2:0] modrm_reg
);

    assign ext_len   = modrm_ext_len(modrm, sib_base);
    assign modrm_reg = modrm[5:3];

endmodule

// File: rtl/x86_length_decoder.sv
// x86-64 instruction-length decoder over a MAX_LEN byte window, plus trace registers.
// Latency: length/illegal combinational (zero cycles); trace state updates on the next edge.
// Backpressure: can_decode=0 forces length 0 and freezes the trace registers.
module x86_length_decoder
    import x86_decode_pkg::*;
#(
    parameter int MAX_LEN = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   can_decode,
    input  logic [63:0]            fetch_rip,
    input  logic [0:8*MAX_LEN-1]   decode_bytes,
    output logic [3:0]             bytes_decoded_this_cycle,
    output logic                   illegal,
    output logic [63:0]            insn_count,
    output logic [3:0]             last_len,
    output logic [63:0]            last_rip,
    output logic                   illegal_seen
);

    logic [7:0] win [0:31];
    logic [4:0] npfx;
    logic       pfx_run;
    logic       opsize16;
    logic       addr32;
    logic       has_rex;
    logic       rex_w;
    logic [4:0] op_pos;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       one_byte_map;
    logic       two_byte_map;
    logic [1:0] nop;
    attr_t      attr;
    logic [4:0] modrm_pos;
    logic [7:0] modrm;
    logic [7:0] sib;
    logic [2:0] ext_len;
    logic [2:0] modrm_reg;
    logic [3:0] imm_len;
    logic [6:0] len_full;
    logic       too_long;
    logic [3:0] len;
    logic       ill;

    // Bytes past the window read as zero so overruns surface as length > MAX_LEN.
    always_comb begin
        for (int k = 0; k < 32; k++) win[k] = 8'h00;
        for (int k = 0; k < MAX_LEN; k++) win[k] = decode_bytes[8*k +: 8];
    end

    always_comb begin
        npfx     = 5'd0;
        pfx_run  = 1'b1;
        opsize16 = 1'b0;
        addr32   = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (pfx_run && is_legacy_prefix(win[i])) begin
                npfx = 5'(i + 1);
                if (win[i] == PFX_OPSIZE)   opsize16 = 1'b1;
                if (win[i] == PFX_ADDRSIZE) addr32   = 1'b1;
            end else begin
                pfx_run = 1'b0;
            end
        end
        has_rex = (npfx < 5'(MAX_LEN)) && (win[npfx] inside {[REX_LO:REX_HI]});
        rex_w   = has_rex && win[npfx][3];
        op_pos  = npfx + {4'd0, has_rex};
    end

    always_comb begin
        b0           = win[op_pos];
        b1           = win[5'(op_pos + 5'd1)];
        one_byte_map = 1'b0;
        two_byte_map = 1'b0;
        attr.has_modrm  = 1'b1;
        attr.imm        = IK_NONE;
        attr.illegal_64 = 1'b0;
        if (b0 == OPC_ESC) begin
            if (b1 == OPC_MAP38) begin
                nop = 2'd3;
            end else if (b1 == OPC_MAP3A) begin
                nop      = 2'd3;
                attr.imm = IK_IMM8;
            end else begin
                nop          = 2'd2;
                two_byte_map = 1'b1;
                attr         = two_byte_attr(b1);
            end
        end else begin
            nop          = 2'd1;
            one_byte_map = 1'b1;
            attr         = one_byte_attr(b0);
        end
        modrm_pos = op_pos + {3'd0, nop};
        modrm     = win[modrm_pos];
        sib       = win[5'(modrm_pos + 5'd1)];
    end

    x86_modrm_len u_modrm_len (
        .modrm     (modrm),
        .sib_base  (sib[2:0]),
        .ext_len   (ext_len),
        .modrm_reg (modrm_reg)
    );

    always_comb begin
        case (attr.imm)
            IK_IMM8:   imm_len = 4'd1;
            IK_IMM16:  imm_len = 4'd2;
            // Two-byte Jcc rel32 stays 4 bytes regardless of operand-size prefix
            IK_IMMZ:   imm_len = (two_byte_map || !opsize16) ? 4'd4 : 4'd2;
            IK_IMMV64: imm_len = rex_w ? 4'd8 : (opsize16 ? 4'd2 : 4'd4);
            IK_IMM24:  imm_len = 4'd3;
            IK_MOFFS:  imm_len = addr32 ? 4'd4 : 4'd8;
            default:   imm_len = 4'd0;
        endcase
        if (one_byte_map && (b0 == 8'hF6 || b0 == 8'hF7) && modrm_reg > 3'd1)
            imm_len = 4'd0;
        len_full = 7'(op_pos) + 7'(nop) + 7'(imm_len)
                 + (attr.has_modrm ? 7'(ext_len) + 7'd1 : 7'd0);
        too_long = (op_pos >= 5'(MAX_LEN)) || (len_full > 7'(MAX_LEN));
        len      = too_long ? 4'(MAX_LEN) : len_full[3:0];
        ill      = too_long || attr.illegal_64;
    end

    assign bytes_decoded_this_cycle = can_decode ? len : 4'd0;
    assign illegal                  = can_decode && ill;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            insn_count   <= 64'd0;
            last_len     <= 4'd0;
            last_rip     <= 64'd0;
            illegal_seen <= 1'b0;
        end else if (can_decode) begin
            insn_count   <= insn_count + 64'd1;
            last_len     <= len;
            last_rip     <= fetch_rip;
            illegal_seen <= illegal_seen | ill;
        end
    end

endmodule

// File: tb/tb_x86_length_decoder.sv
// Directed and randomized checks of x86_length_decoder against a byte-level reference model.
module tb_x86_length_decoder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         can_decode;
    logic [63:0]  fetch_rip;
    logic [0:119] decode_bytes;
    logic [3:0]   bytes_decoded_this_cycle;
    logic         illegal;
    logic [63:0]  insn_count;
    logic [3:0]   last_len;
    logic [63:0]  last_rip;
    logic         illegal_seen;

    x86_length_decoder #(.MAX_LEN(15)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .can_decode               (can_decode),
        .fetch_rip                (fetch_rip),
        .decode_bytes             (decode_bytes),
        .bytes_decoded_this_cycle (bytes_decoded_this_cycle),
        .illegal                  (illegal),
        .insn_count               (insn_count),
        .last_len                 (last_len),
        .last_rip                 (last_rip),
        .illegal_seen             (illegal_seen)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  cur_w [15];
    logic [63:0] e_cnt;
    logic [63:0] e_rip;
    logic [3:0]  e_len;
    logic        e_ill;
    logic [7:0]  pfx_list [11] = '{8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h36, 8'h3E,
                                   8'h26, 8'h64, 8'h65, 8'h66, 8'h67};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gb(input int i);
        return (i < 15) ? cur_w[i] : 8'h00;
    endfunction

    function automatic bit is_pfx(input logic [7:0] b);
        for (int i = 0; i < 11; i++) if (pfx_list[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: walk the instruction byte by byte, adding up field sizes.
    function automatic void ref_decode(output int len, output bit ill);
        int p = 0, nop = 1, imm = 0, ext = 0;
        bit o16 = 0, a32 = 0, w = 0, mr = 0;
        logic [7:0] op, x, m;
        int md, rm, rg;
        ill = 0;
        while (p < 15 && is_pfx(cur_w[p])) begin
            if (cur_w[p] == 8'h66) o16 = 1;
            if (cur_w[p] == 8'h67) a32 = 1;
            p++;
        end
        if (p < 15 && cur_w[p] >= 8'h40 && cur_w[p] <= 8'h4F) begin
            w = cur_w[p][3];
            p++;
        end
        if (p >= 15) begin len = 15; ill = 1; return; end
        op = gb(p);
        x  = gb(p + 1);
        if (op == 8'h0F) begin
            nop = (x == 8'h38 || x == 8'h3A) ? 3 : 2;
            if (nop == 3) begin
                mr  = 1;
                imm = (x == 8'h3A) ? 1 : 0;
            end else begin
                mr = !(x inside {[8'h05:8'h09], 8'h0B, [8'h30:8'h37], 8'h77, [8'h80:8'h8F],
                                 [8'hA0:8'hA2], [8'hA8:8'hAA], [8'hC8:8'hCF]});
                if (x inside {[8'h70:8'h73], 8'hA4, 8'hAC, 8'hBA, 8'hC2, [8'hC4:8'hC6]}) imm = 1;
                if (x >= 8'h80 && x <= 8'h8F) imm = 4;
            end
        end else if (op inside {8'h06, 8'h07, 8'h0E, 8'h16, 8'h17, 8'h1E, 8'h1F, 8'h27, 8'h2F,
                                8'h37, 8'h3F, 8'h60, 8'h61, 8'h62, 8'h82, 8'h9A, 8'hC4,
                                8'hC5, 8'hD4, 8'hD5, 8'hD6, 8'hEA}) begin
            ill = 1;
        end else begin
            mr = (op < 8'h40 && (op % 8) < 4)
               || op inside {8'h63, 8'h69, 8'h6B, [8'h80:8'h8F], 8'hC0, 8'hC1, 8'hC6, 8'hC7,
                             [8'hD0:8'hD3], [8'hD8:8'hDF], 8'hF6, 8'hF7, 8'hFE, 8'hFF};
            rg = int'(gb(p + 1)) / 8 % 8;
            if ((op < 8'h40 && op % 8 == 4) || op inside {8'h6A, 8'h6B, [8'h70:8'h7F], 8'h80,
                8'h83, 8'hA8, [8'hB0:8'hB7], 8'hC0, 8'hC1, 8'hC6, 8'hCD, [8'hE0:8'hE7], 8'hEB})
                imm = 1;
            if ((op < 8'h40 && op % 8 == 5) || op inside {8'h68, 8'h69, 8'h81, 8'hA9, 8'hC7,
                8'hE8, 8'hE9})
                imm = o16 ? 2 : 4;
            if (op == 8'hF6 && rg < 2) imm = 1;
            if (op == 8'hF7 && rg < 2) imm = o16 ? 2 : 4;
            if (op >= 8'hB8 && op <= 8'hBF) imm = w ? 8 : (o16 ? 2 : 4);
            if (op == 8'hC2 || op == 8'hCA) imm = 2;
            if (op == 8'hC8) imm = 3;
            if (op >= 8'hA0 && op <= 8'hA3) imm = a32 ? 4 : 8;
        end
        if (mr) begin
            m  = gb(p + nop);
            md = int'(m) / 64;
            rm = int'(m) % 8;
            if (md != 3 && rm == 4) ext += 1;
            if (md == 1) ext += 1;
            if (md == 2) ext += 4;
            if (md == 0 && (rm == 5 || (rm == 4 && int'(gb(p + nop + 1)) % 8 == 5))) ext += 4;
        end
        len = p + nop + imm + (mr ? 1 + ext : 0);
        if (len > 15) begin len = 15; ill = 1; end
    endfunction

    task automatic load_hex(input logic [119:0] v, input int n);
        for (int k = 0; k < 15; k++) cur_w[k] = (k < n) ? v[8*(n-1-k) +: 8] : 8'h00;
    endtask

    task automatic apply();
        for (int k = 0; k < 15; k++) decode_bytes[8*k +: 8] = cur_w[k];
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".insn_count"},   insn_count,            e_cnt);
        chk({tag, ".last_len"},     64'(last_len),         64'(e_len));
        chk({tag, ".last_rip"},     last_rip,              e_rip);
        chk({tag, ".illegal_seen"}, 64'(illegal_seen),     64'(e_ill));
    endtask

    // Entered and left at a negedge.
    task automatic step(input string tag, input bit cd, input int want_len, input bit want_ill);
        can_decode = cd;
        fetch_rip  = {$urandom, $urandom};
        apply();
        #1;
        chk({tag, ".len"},     64'(bytes_decoded_this_cycle), 64'(want_len));
        chk({tag, ".illegal"}, 64'(illegal),                  64'(want_ill));
        if (cd) begin
            e_cnt = e_cnt + 64'd1;
            e_len = 4'(want_len);
            e_rip = fetch_rip;
            e_ill = e_ill | want_ill;
        end
        @(posedge clk);
        #1;
        chk_regs(tag);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  l;
        bit  il;
        bit  cd;
        int  k;
        reset_n      = 1'b0;
        can_decode   = 1'b0;
        fetch_rip    = 64'd0;
        decode_bytes = '0;
        e_cnt = 0; e_rip = 0; e_len = 0; e_ill = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_regs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        load_hex(120'h90, 1);                       step("nop", 1, 1, 0);
        chk("nop.count_is_1", insn_count, 64'd1);
        load_hex(120'h48B81122334455667788, 10);   step("rexw_imm64", 1, 10, 0);
        load_hex(120'hB812345678, 5);              step("mov_imm32", 1, 5, 0);
        load_hex(120'h488B442408, 5);              step("sib_disp8", 1, 5, 0);
        load_hex(120'hC70544332211DDCCBBAA, 10);   step("rip_imm32", 1, 10, 0);
        load_hex(120'h660F3A0FC108, 6);            step("map3a", 1, 6, 0);
        load_hex(120'h0F8578563412, 6);            step("jcc_rel32", 1, 6, 0);
        load_hex(120'h66B83412, 4);                step("mov_imm16", 1, 4, 0);
        load_hex({15{8'h66}}, 15);                 step("all_prefix", 1, 15, 1);
        chk("all_prefix.sticky", 64'(illegal_seen), 64'd1);
        load_hex(120'h06, 1);                      step("push_es", 1, 1, 1);
        load_hex(120'hC70544332211DDCCBBAA, 10);   step("gated", 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < 15; j++) cur_w[j] = 8'($urandom);
            k = 0;
            for (int j = $urandom_range(0, 3); j > 0; j--) cur_w[k++] = pfx_list[$urandom_range(0, 10)];
            if ($urandom_range(0, 1) == 1) cur_w[k++] = 8'h40 | 8'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: begin cur_w[k] = 8'h0F; end
                1: begin cur_w[k] = 8'h0F; cur_w[k+1] = 8'h38; end
                2: begin cur_w[k] = 8'h0F; cur_w[k+1] = 8'h3A; end
                default: ;
            endcase
            cd = ($urandom_range(0, 7) != 0);
            ref_decode(l, il);
            step("rand", cd, cd ? l : 0, cd ? il : 1'b0);
        end

        load_hex(120'h90, 1);
        can_decode = 1'b1;
        apply();
        reset_n = 1'b0;
        #1;
        chk("midreset.insn_count",   insn_count,            64'd0);
        chk("midreset.last_len",     64'(last_len),         64'd0);
        chk("midreset.last_rip",     last_rip,              64'd0);
        chk("midreset.illegal_seen", 64'(illegal_seen),     64'd0);
        chk("midreset.comb_len",     64'(bytes_decoded_this_cycle), 64'd1);
        @(posedge clk);
        #1;
        chk("midreset.held", insn_count, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        e_cnt = 0; e_rip = 0; e_len = 0; e_ill = 0;
        load_hex(120'h66B83412, 4);                step("post_reset", 1, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
